enc4x2_pipe: RTL
================

# enc4x2_pipe

Registered 4-to-2 priority encoder with a valid/ready handshake and a built-in switching-activity counter. It is the inverse of the 2x4 decoder: it converts a 4-bit one-hot (decoded) word back to a 2-bit binary code. It flags malformed (non-one-hot) input and accumulates the Hamming distance between successive output codes, giving the power-estimation path toggle activity directly.

## Interface

Parameters:
- `CNT_W`, default 16: width of the toggle counter. Must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  `in` holds a word to encode.
- `in_ready`  out  1  block can accept a word this cycle.
- `in`  in  4  one-hot decoded word.
- `out_valid`  out  1  `out` / `out_err` hold a result.
- `out_ready`  in  1  downstream consumes the result this cycle.
- `out`  out  2  binary code.
- `out_err`  out  1  the word for this result was not one-hot.
- `clr_cnt`  in  1  synchronous clear of `toggle_cnt`.
- `toggle_cnt`  out  CNT_W  saturating count of output-code bit toggles.

## Operation

Encoding rule (priority, highest index wins):
- `in[3]` set gives 2'b11; else `in[2]` gives 2'b10; else `in[1]` gives 2'b01; else 2'b00.
- `out_err` = 1 when `in` is 4'b0000 or has two or more bits set; otherwise 0.
- Example: `in` = 4'b0000 gives `out` = 00, `out_err` = 1. `in` = 4'b0110 gives `out` = 10, `out_err` = 1.

Output stage: a one-entry register with two states, EMPTY and FULL.
- `in_ready` = EMPTY | `out_ready`. It is combinational from `out_ready`; there is no combinational path from `in_valid`.
- An accept happens when `in_valid` & `in_ready`.
- EMPTY: an accept loads the result and moves to FULL.
- FULL with `out_ready`=1: the result is consumed. A simultaneous accept reloads and stays FULL; with no accept, the state moves to EMPTY.
- FULL with `out_ready`=0: the register holds. `out`, `out_err` and `out_valid` must stay stable.
- `out_valid` = FULL.

Toggle counter:
- `prev_code` is a 2-bit register holding the code of the last accepted word.
- On each accept, `toggle_cnt` += popcount(new code XOR `prev_code`), and `prev_code` takes the new code.
- Error words count like any other word; they use their encoded value.
- Addition saturates at 2^CNT_W − 1 and never wraps.
- `clr_cnt` with no accept: the counter goes to 0 next edge.
- `clr_cnt` with an accept in the same cycle: the counter goes to that accept's increment only (clear first, then add).
- `clr_cnt` does not touch `prev_code`.

Reset (asynchronous, while `rst_n` = 0):
- State goes to EMPTY, so `out_valid` = 0.
- `out` = 00, `out_err` = 0, `prev_code` = 00, `toggle_cnt` = 0.
- `in_ready` = 1 once `rst_n` is high.
- Reset asserted mid-transfer discards the held result. No partial count is retained.

## Timing

- Latency: a word accepted at edge N appears on `out` with `out_valid`=1 right after edge N.
- Throughput: one word per cycle while `out_ready`=1.
- `toggle_cnt` reflects an accept right after that same edge.
- Release of `rst_n` is taken as synchronous to `clk` by the integrator. The block adds no synchronizer.

## Test plan

- **Decoder-inverse sequence.** `out_ready`=1; words 0001, 0010, 0100, 1000, 0100, 0001, 0010 on consecutive cycles.
  - Expect `out` = 0, 1, 2, 3, 2, 0, 1, each one cycle after its accept.
  - Expect `out_err` = 0 throughout and final `toggle_cnt` = 7 (0+1+2+1+1+1+1).
- **Malformed input.** 0000, then 0110, then 1111.
  - Expect `out` = 00/10/11 with `out_err` = 1 each time.
  - Expect `toggle_cnt` to advance by 0, 1, 1.
- **Backpressure.** Load 1000 with `out_ready`=0 for 3 cycles while `in_valid`=1 carries 0001.
  - Expect `out` to hold 11 with `out_valid`=1, `in_ready`=0, and no count change.
  - Raise `out_ready`: expect 11 consumed, then 00 delivered, and `toggle_cnt` +2.
- **Saturation.** `CNT_W`=2; alternate 0001/1000 for 4 accepts.
  - Expect `toggle_cnt` 0 → 2 → 3 → 3 (sticks at 3).
- **Clear collision.** `toggle_cnt`=5; assert `clr_cnt` in the same cycle as an accept that toggles 2 bits.
  - Expect `toggle_cnt` = 2.
  - Assert `clr_cnt` alone: expect 0.
- **Reset mid-operation.** Drop `rst_n` while FULL with `out_ready`=0 and `toggle_cnt`=4.
  - Expect immediately `out_valid`=0, `out`=00, `out_err`=0, `toggle_cnt`=0.
  - After release, the first accept of 0010 gives `toggle_cnt`=1.

Source files
------------

// File: rtl/enc4x2_pipe.sv
// Registered 4-to-2 priority encoder with valid/ready output stage and a
// saturating counter of output-code bit toggles for activity estimation.
module enc4x2_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out,
  output logic             out_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] toggle_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_nx;
  logic             accept;
  logic [1:0]       code;
  logic             err;
  logic [1:0]       prev_code;
  logic [1:0]       diff;
  logic [1:0]       inc;
  logic [CNT_W:0]   sum;

  assign in_ready  = (state == EMPTY) | out_ready;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == FULL);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    code = 2'b00;
    if (in[3])      code = 2'b11;
    else if (in[2]) code = 2'b10;
    else if (in[1]) code = 2'b01;
    // Zero bits, or clearing the lowest set bit leaves something behind.
    err = (in == 4'b0000) || ((in & (in - 4'd1)) != 4'b0000);
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: if (accept) state_nx = FULL;
      FULL:  if (out_ready && !accept) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  // Clear is applied before the add, so a colliding accept leaves only its
  // own increment in the counter.
  always_comb begin
    diff = code ^ prev_code;
    inc  = {1'b0, diff[1]} + {1'b0, diff[0]};
    sum  = {1'b0, (clr_cnt ? {CNT_W{1'b0}} : toggle_cnt)}
         + {{(CNT_W-1){1'b0}}, inc};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      out        <= 2'b00;
      out_err    <= 1'b0;
      prev_code  <= 2'b00;
      toggle_cnt <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        out        <= code;
        out_err    <= err;
        prev_code  <= code;
        toggle_cnt <= sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      end else if (clr_cnt) begin
        toggle_cnt <= '0;
      end
    end
  end

endmodule
